crossbar_seg7_scan: RTL and testbench
=====================================

CROSSBAR_SEG7_SCAN -- requirements
Module: crossbar_seg7_scan

Interface
REQ-001 The block SHALL have parameter DIV, default 100000, giving the number of clk cycles each digit is displayed (legal range 2..2^20).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state SHALL be updated on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset; it SHALL be asynchronous and active-low.
REQ-004 The block SHALL have port out1, input, 4, crossbar output 1, displayed on digit 0.
REQ-005 The block SHALL have port out2, input, 4, crossbar output 2, displayed on digit 1.
REQ-006 The block SHALL have port control, input, 1, crossbar control, displayed on digit 2 as hex 0 or 1.
REQ-007 The block SHALL have port hold, input, 1; when high it freezes the snapshot.
REQ-008 The block SHALL have port an, output, 4, active-low digit enables, with an[0] driving digit 0.
REQ-009 The block SHALL have port seg, output, 7, active-low segments ordered {g,f,e,d,c,b,a}.
REQ-010 The block SHALL have port dp, output, 1, the active-low decimal point.

Function
REQ-011 The block SHALL hold a 9-bit snapshot {control,out2,out1}; when hold=0 it SHALL load the inputs every cycle, and when hold=1 it SHALL keep its previous value.
REQ-012 The block SHALL have a tick counter that counts 0..DIV-1 and wraps to 0; the cycle in which it equals DIV-1 SHALL be a tick.
REQ-013 The block SHALL have a 2-bit digit index, idx, that advances on every tick, wraps 3->0, and is unchanged otherwise.
REQ-014 The outputs an, seg and dp SHALL be registered: each cycle they SHALL load the value decoded from the current idx and snapshot, giving 1 cycle of latency.
REQ-015 The active-low digit enable SHALL be an = ~(4'b0001 << idx), so exactly one digit is enabled after the first post-reset clock.
REQ-016 The digit values SHALL be: idx 0 -> out1 snapshot; idx 1 -> out2 snapshot; idx 2 -> {3'b000,control snapshot}; idx 3 -> blank (seg=7'b1111111).
REQ-017 The hex decode for values 0..F SHALL be 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex encodings of seg[6:0]).
REQ-018 dp SHALL be 0 only when idx=3 and hold=1, as the hold indicator, and SHALL be 1 otherwise.
REQ-019 When hold changes in the same cycle as a tick, the snapshot rule (REQ-011) and the idx advance (REQ-013) SHALL both apply independently in that cycle.
REQ-020 A change on the inputs SHALL appear on seg no later than 2 cycles after it, while the affected digit is enabled and hold=0.
REQ-021 The state machine SHALL be a free-running cycle SCAN0->SCAN1->SCAN2->SCAN3->SCAN0, advancing on ticks only, with no other states.

Reset
REQ-022 While rst_n=0, the block SHALL force: counter=0, idx=0, snapshot=0, an=4'b1111, seg=7'b1111111, dp=1.
REQ-023 Reset asserted mid-scan SHALL immediately return all state to the REQ-022 values.
REQ-024 On the first clk edge after rst_n deasserts, the outputs SHALL be an=4'b1110 and seg showing the digit-0 snapshot.

Verification
REQ-025 Reset release scenario: DIV=4, out1=3, out2=5, control=0, hold=0 -> at cycle 1, an=1110 and seg=7'h30; at cycle 5, an=1101 and seg=7'h12; at cycle 9, an=1011 and seg=7'h40; at cycle 13, an=0111, seg=7'h7F and dp=1; at cycle 17, an=1110.
REQ-026 Hold scenario: out1=A, hold=1, then out1=F -> digit 0 stays 7'h08, and digit 3 shows dp=0; after hold=0, digit 0 shows 7'h0E within 2 cycles.
REQ-027 Full hex sweep scenario: out1 swept 0..F, one value per 4 scan periods -> each seg value matches REQ-017.
REQ-028 Reset mid-scan scenario: rst_n pulsed low while idx=2 -> outputs reach reset values asynchronously, before the next edge; after release, the scan restarts at digit 0.
REQ-029 Tick/hold collision scenario: hold rises on a tick cycle -> idx advances, and the snapshot is frozen with the value captured on the prior cycle.

Source files
------------

// File: rtl/crossbar_seg7_scan.sv
// Scans the crossbar state {control,out2,out1} onto a 4-digit active-low 7-segment display.
// Latency: outputs are registered, 1 cycle after the selected digit/snapshot; digit period DIV cycles.
// Backpressure: none; free-running scan, hold freezes the displayed snapshot.
module crossbar_seg7_scan #(
    parameter int unsigned DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] out1,
    input  logic [3:0] out2,
    input  logic       control,
    input  logic       hold,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [6:0] SEG_BLANK = 7'b111_1111;

    typedef enum logic [1:0] {
        SCAN0 = 2'd0,
        SCAN1 = 2'd1,
        SCAN2 = 2'd2,
        SCAN3 = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick;
    logic [8:0]    snap_q, snap_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [1:0]    idx;
    logic [3:0]    digit_val;
    logic          digit_blank;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        tick  = (cnt_q == CNT_LAST);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_comb begin
        snap_d = hold ? snap_q : {control, out2, out1};
    end

    // Scan state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCAN0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: advance one digit per tick
    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                SCAN0:   state_d = SCAN1;
                SCAN1:   state_d = SCAN2;
                SCAN2:   state_d = SCAN3;
                default: state_d = SCAN0;
            endcase
        end
    end

    // Decode uses the snapshot being loaded this cycle so a live input reaches seg one edge later.
    always_comb begin
        idx         = state_q;
        digit_val   = 4'h0;
        digit_blank = 1'b0;
        case (state_q)
            SCAN0:   digit_val = snap_d[3:0];
            SCAN1:   digit_val = snap_d[7:4];
            SCAN2:   digit_val = {3'b000, snap_d[8]};
            default: digit_blank = 1'b1;
        endcase
        an_d  = ~(4'b0001 << idx);
        seg_d = digit_blank ? SEG_BLANK : hex7(digit_val);
        dp_d  = ~((state_q == SCAN3) && hold);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            snap_q <= '0;
            an_q   <= 4'b1111;
            seg_q  <= SEG_BLANK;
            dp_q   <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            snap_q <= snap_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_crossbar_seg7_scan.sv
// Bench for crossbar_seg7_scan: cycle-indexed display model plus directed literal checks.
module tb_crossbar_seg7_scan;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] out1 = 4'h0;
    logic [3:0] out2 = 4'h0;
    logic       control = 1'b0;
    logic       hold = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int vecs = 0;
    int errs = 0;
    int n = 0;
    int md;
    int mval;
    int exp_seg;
    logic [8:0] msnap = '0;
    logic started = 1'b0;
    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    crossbar_seg7_scan #(.DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .out1(out1), .out2(out2), .control(control),
        .hold(hold), .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int expv);
        vecs++;
        if (got !== expv) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, got, expv, $time);
        end
    endtask

    task automatic edges(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic wait_an(input logic [3:0] t, input int budget, input string nm);
        int k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (an !== t && k < budget);
        chk(nm, int'(an), int'(t));
    endtask

    // Model: edge n after reset shows digit ((n-1)/DIV)%4 of the snapshot as of that edge.
    always begin
        @(posedge clk);
        #1;
        if (started) begin
            if (!rst_n) begin
                n = 0;
                msnap = '0;
                chk("model_rst_an", int'(an), 'hF);
                chk("model_rst_seg", int'(seg), 'h7F);
                chk("model_rst_dp", int'(dp), 1);
            end else begin
                n++;
                if (!hold) msnap = {control, out2, out1};
                md = ((n - 1) / DIV) % 4;
                if (md == 0) mval = int'(msnap[3:0]);
                else if (md == 1) mval = int'(msnap[7:4]);
                else mval = int'(msnap[8]);
                exp_seg = (md == 3) ? 'h7F : int'(hex_tab[mval]);
                chk("model_an", int'(an), 15 - (1 << md));
                chk("model_seg", int'(seg), exp_seg);
                chk("model_dp", int'(dp), (md == 3 && hold) ? 0 : 1);
            end
        end
    end

    initial begin
        out1 = 4'h3; out2 = 4'h5; control = 1'b0; hold = 1'b0;
        #2 rst_n = 1'b0;
        started = 1'b1;
        #1;
        chk("rst_async_an", int'(an), 'hF);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Reset release scan sequence
        edges(1);
        chk("c1_an", int'(an), 'hE);
        chk("c1_seg", int'(seg), 'h30);
        edges(4);
        chk("c5_an", int'(an), 'hD);
        chk("c5_seg", int'(seg), 'h12);
        edges(4);
        chk("c9_an", int'(an), 'hB);
        chk("c9_seg", int'(seg), 'h40);
        edges(4);
        chk("c13_an", int'(an), 'h7);
        chk("c13_seg", int'(seg), 'h7F);
        chk("c13_dp", int'(dp), 1);
        edges(4);
        chk("c17_an", int'(an), 'hE);

        // Hold freezes digit 0 at A while input moves to F
        @(negedge clk) out1 = 4'hA;
        @(negedge clk) hold = 1'b1;
        @(negedge clk) out1 = 4'hF;
        wait_an(4'hE, 40, "hold_wait_d0");
        chk("hold_d0_seg", int'(seg), 'h08);
        wait_an(4'h7, 40, "hold_wait_d3");
        chk("hold_dp", int'(dp), 0);
        wait_an(4'hE, 40, "unhold_wait_d0");
        @(negedge clk) hold = 1'b0;
        edges(2);
        chk("unhold_an", int'(an), 'hE);
        chk("unhold_seg", int'(seg), 'h0E);

        // Hold rises on a tick: snapshot keeps the value from the prior cycle
        @(negedge clk) out1 = 4'h7;
        begin
            int k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (n % DIV != DIV - 1 && k < 40);
            chk("tick_align", n % DIV, DIV - 1);
        end
        out1 = 4'h9;
        hold = 1'b1;
        wait_an(4'hE, 40, "coll_wait_d0");
        chk("coll_seg", int'(seg), 'h78);
        @(negedge clk) hold = 1'b0;

        // Asynchronous reset while digit 2 is shown
        wait_an(4'hB, 40, "mid_wait_d2");
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_an", int'(an), 'hF);
        chk("mid_rst_seg", int'(seg), 'h7F);
        chk("mid_rst_dp", int'(dp), 1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        edges(1);
        chk("restart_an", int'(an), 'hE);
        chk("restart_seg", int'(seg), 'h10);
        edges(4);
        chk("restart_c5_an", int'(an), 'hD);

        // Hex sweep on digit 0, four scan periods per value
        for (int v = 0; v < 16; v++) begin
            @(negedge clk) out1 = 4'(v);
            repeat (16 * DIV) @(posedge clk);
        end
        #2;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
